// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bus bundle for the multi-ported register file.
//   Read side : raddr0/raddr1 in, rdata0/rdata1 and rbusy0/rbusy1 out.
//   Write side: wen0/wen1, waddr0/waddr1, wdata0/wdata1 in.
//   Scoreboard: alloc_en/alloc_addr in, busy_cnt out (AW+1 bits).
// master = the agent driving requests; slave = regfile_mp.
interface regfile_mp_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   raddr0;
  logic [AW-1:0]   raddr1;
  logic [XLEN-1:0] rdata0;
  logic [XLEN-1:0] rdata1;
  logic            rbusy0;
  logic            rbusy1;
  logic            wen0;
  logic            wen1;
  logic [AW-1:0]   waddr0;
  logic [AW-1:0]   waddr1;
  logic [XLEN-1:0] wdata0;
  logic [XLEN-1:0] wdata1;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic [AW:0]     busy_cnt;

  modport master (
    output raddr0, raddr1, wen0, wen1, waddr0, waddr1, wdata0, wdata1,
           alloc_en, alloc_addr,
    input  rdata0, rdata1, rbusy0, rbusy1, busy_cnt
  );

  modport slave (
    input  raddr0, raddr1, wen0, wen1, waddr0, waddr1, wdata0, wdata1,
           alloc_en, alloc_addr,
    output rdata0, rdata1, rbusy0, rbusy1, busy_cnt
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp -- 2-read / 2-write register file with a busy scoreboard.
//   clk : rising-edge clock for all state.
//   rst : synchronous, active-low; clears data, busy bits and busy_cnt.
//   bus : regfile_mp_if.slave
//         - combinational reads (optional same-cycle write bypass)
//         - two write ports, port 1 wins on an address collision
//         - alloc_en marks a register busy; a write clears it; set wins
//         - busy_cnt is the registered population count of busy bits
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   busy_cnt_q;
  logic [CW-1:0]   busy_cnt_d;

  logic wr0_ok;
  logic wr1_ok;
  logic alloc_ok;
  logic byp_en;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Port 1 is checked first so it overrides port 0 on a shared address.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   ra,
    input logic [XLEN-1:0] stored,
    input logic            en,
    input logic            w0,
    input logic [AW-1:0]   a0,
    input logic [XLEN-1:0] d0,
    input logic            w1,
    input logic [AW-1:0]   a1,
    input logic [XLEN-1:0] d1
  );
    if (is_zero_reg(ra))       return '0;
    if (en && w1 && (a1 == ra)) return d1;
    if (en && w0 && (a0 == ra)) return d0;
    return stored;
  endfunction

  // Writes to the hardwired zero register count as no write at all:
  // they neither store data, bypass, nor clear a busy bit.
  always_comb begin
    wr0_ok   = bus.wen0 && !is_zero_reg(bus.waddr0);
    wr1_ok   = bus.wen1 && !is_zero_reg(bus.waddr1);
    alloc_ok = bus.alloc_en && !is_zero_reg(bus.alloc_addr);
    // Bypass is suppressed while reset is asserted: that cycle's write is dropped.
    byp_en   = (BYPASS != 0) && rst;
  end

  always_comb begin
    regs_d = regs_q;
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_d[i] = '0;
    end else begin
      if (wr0_ok) regs_d[bus.waddr0] = bus.wdata0;
      if (wr1_ok) regs_d[bus.waddr1] = bus.wdata1;
    end
  end

  // Clears are applied before the set so an allocation of a register
  // being written back in the same cycle leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (!rst) begin
      busy_d = '0;
    end else begin
      if (wr0_ok)   busy_d[bus.waddr0]     = 1'b0;
      if (wr1_ok)   busy_d[bus.waddr1]     = 1'b0;
      if (alloc_ok) busy_d[bus.alloc_addr] = 1'b1;
    end
    busy_cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    busy_q     <= busy_d;
    busy_cnt_q <= busy_cnt_d;
  end

  always_comb begin
    bus.rdata0   = read_port(bus.raddr0, regs_q[bus.raddr0], byp_en,
                             wr0_ok, bus.waddr0, bus.wdata0,
                             wr1_ok, bus.waddr1, bus.wdata1);
    bus.rdata1   = read_port(bus.raddr1, regs_q[bus.raddr1], byp_en,
                             wr0_ok, bus.waddr0, bus.wdata0,
                             wr1_ok, bus.waddr1, bus.wdata1);
    bus.rbusy0   = busy_q[bus.raddr0];
    bus.rbusy1   = busy_q[bus.raddr1];
    bus.busy_cnt = busy_cnt_q;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- bench for regfile_mp. Two instances (bypass on/off) share
// one stimulus stream and are compared against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [XLEN-1:0] mreg  [NREG];
  bit              mbusy [NREG];

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG)) bus    ();
  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG)) bus_nb ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb.slave)
  );

  assign bus_nb.raddr0     = bus.raddr0;
  assign bus_nb.raddr1     = bus.raddr1;
  assign bus_nb.wen0       = bus.wen0;
  assign bus_nb.wen1       = bus.wen1;
  assign bus_nb.waddr0     = bus.waddr0;
  assign bus_nb.waddr1     = bus.waddr1;
  assign bus_nb.wdata0     = bus.wdata0;
  assign bus_nb.wdata1     = bus.wdata1;
  assign bus_nb.alloc_en   = bus.alloc_en;
  assign bus_nb.alloc_addr = bus.alloc_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [63:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 64'd0;
    if (byp && rst) begin
      if (bus.wen1 && bus.waddr1 == a) return bus.wdata1;
      if (bus.wen0 && bus.waddr0 == a) return bus.wdata0;
    end
    return mreg[a];
  endfunction

  function automatic logic [63:0] exp_cnt();
    int n;
    n = 0;
    for (int i = 0; i < NREG; i++) n += int'(mbusy[i]);
    return 64'(n);
  endfunction

  task automatic model_update();
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mreg[i]  = '0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (bus.wen0 && bus.waddr0 != 0) begin
        mreg[bus.waddr0]  = bus.wdata0;
        mbusy[bus.waddr0] = 1'b0;
      end
      if (bus.wen1 && bus.waddr1 != 0) begin
        mreg[bus.waddr1]  = bus.wdata1;
        mbusy[bus.waddr1] = 1'b0;
      end
      if (bus.alloc_en && bus.alloc_addr != 0) mbusy[bus.alloc_addr] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("rdata0_byp",  bus.rdata0,      exp_read(bus.raddr0, 1'b1));
    chk("rdata1_byp",  bus.rdata1,      exp_read(bus.raddr1, 1'b1));
    chk("rdata0_nob",  bus_nb.rdata0,   exp_read(bus.raddr0, 1'b0));
    chk("rdata1_nob",  bus_nb.rdata1,   exp_read(bus.raddr1, 1'b0));
    chk("rbusy0",      64'(bus.rbusy0), 64'(mbusy[bus.raddr0]));
    chk("rbusy1",      64'(bus.rbusy1), 64'(mbusy[bus.raddr1]));
    chk("busy_cnt",    64'(bus.busy_cnt),    exp_cnt());
    chk("busy_cnt_nb", 64'(bus_nb.busy_cnt), exp_cnt());
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst            = 1'b1;
    bus.wen0       = 1'b0;
    bus.wen1       = 1'b0;
    bus.alloc_en   = 1'b0;
    bus.waddr0     = '0;
    bus.waddr1     = '0;
    bus.wdata0     = '0;
    bus.wdata1     = '0;
    bus.alloc_addr = '0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    bus.raddr0 = '0;
    bus.raddr1 = '0;
    rst = 1'b0;
    @(posedge clk);
    model_update();
    @(negedge clk);

    // Post-reset sweep of every address on both ports.
    idle();
    for (int i = 0; i < NREG; i++) begin
      bus.raddr0 = AW'(i);
      bus.raddr1 = AW'(NREG - 1 - i);
      #1;
      chk("rst_rdata0", bus.rdata0, 64'd0);
      chk("rst_rdata1", bus.rdata1, 64'd0);
      chk("rst_rbusy0", 64'(bus.rbusy0), 64'd0);
      chk("rst_cnt",    64'(bus.busy_cnt), 64'd0);
      cycle();
    end

    // Same-cycle bypass vs stored value.
    idle();
    bus.wen0 = 1'b1; bus.waddr0 = 5; bus.wdata0 = 64'hDEAD_BEEF; bus.raddr0 = 5;
    #1;
    chk("byp_same",   bus.rdata0,    64'hDEAD_BEEF);
    chk("nobyp_same", bus_nb.rdata0, 64'd0);
    cycle();
    idle();
    bus.raddr0 = 5;
    #1;
    chk("byp_next",   bus.rdata0,    64'hDEAD_BEEF);
    chk("nobyp_next", bus_nb.rdata0, 64'hDEAD_BEEF);
    cycle();

    // Dual write collision and zero register.
    idle();
    bus.wen0 = 1'b1; bus.waddr0 = 7; bus.wdata0 = 64'h11;
    bus.wen1 = 1'b1; bus.waddr1 = 7; bus.wdata1 = 64'h22;
    bus.raddr0 = 7;
    #1;
    chk("dual_byp", bus.rdata0, 64'h22);
    cycle();
    idle();
    bus.raddr0 = 7;
    #1;
    chk("dual_store", bus_nb.rdata0, 64'h22);
    cycle();
    idle();
    bus.wen1 = 1'b1; bus.waddr1 = 0; bus.wdata1 = 64'hFF;
    bus.raddr0 = 0; bus.raddr1 = 0;
    #1;
    chk("zero_byp", bus.rdata0, 64'd0);
    cycle();
    idle();
    #1;
    chk("zero_store", bus.rdata1, 64'd0);
    cycle();

    // Scoreboard allocation, set-over-clear, re-allocation.
    idle();
    bus.alloc_en = 1'b1; bus.alloc_addr = 3;
    cycle();
    idle();
    #1;
    chk("alloc_cnt1", 64'(bus.busy_cnt), 64'd1);
    bus.alloc_en = 1'b1; bus.alloc_addr = 9;
    cycle();
    idle();
    #1;
    chk("alloc_cnt2", 64'(bus.busy_cnt), 64'd2);
    bus.wen0 = 1'b1; bus.waddr0 = 3; bus.wdata0 = 64'h33;
    bus.alloc_en = 1'b1; bus.alloc_addr = 3;
    cycle();
    idle();
    bus.raddr0 = 3; bus.raddr1 = 9;
    #1;
    chk("setwin_busy3", 64'(bus.rbusy0), 64'd1);
    chk("setwin_busy9", 64'(bus.rbusy1), 64'd1);
    chk("setwin_cnt",   64'(bus.busy_cnt), 64'd2);
    bus.alloc_en = 1'b1; bus.alloc_addr = 9;
    cycle();
    idle();
    #1;
    chk("realloc_cnt", 64'(bus.busy_cnt), 64'd2);
    bus.wen1 = 1'b1; bus.waddr1 = 9; bus.wdata1 = 64'h99;
    cycle();
    idle();
    bus.raddr1 = 9;
    #1;
    chk("wb_clear9", 64'(bus.rbusy1), 64'd0);
    chk("wb_cnt",    64'(bus.busy_cnt), 64'd1);

    // Mid-operation reset clears pending busy bits and discards that cycle.
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.alloc_en = 1'b1; bus.alloc_addr = AW'(10 + i);
      cycle();
    end
    idle();
    #1;
    chk("pre_rst_cnt", 64'(bus.busy_cnt), 64'd5);
    rst = 1'b0;
    bus.wen0 = 1'b1; bus.waddr0 = 12; bus.wdata0 = 64'hABCD;
    bus.alloc_en = 1'b1; bus.alloc_addr = 20;
    bus.raddr0 = 12; bus.raddr1 = 7;
    #1;
    chk("rst_nobyp", bus.rdata0, 64'd0);
    chk("rst_stored", bus.rdata1, 64'h22);
    cycle();
    idle();
    for (int i = 0; i < NREG; i++) begin
      bus.raddr0 = AW'(i);
      bus.raddr1 = AW'(i);
      #1;
      chk("mid_rst_rdata", bus.rdata0, 64'd0);
      chk("mid_rst_rbusy", 64'(bus.rbusy1), 64'd0);
      chk("mid_rst_cnt",   64'(bus.busy_cnt), 64'd0);
      cycle();
    end
    idle();
    bus.wen0 = 1'b1; bus.waddr0 = 4; bus.wdata0 = 64'h4444;
    cycle();
    idle();
    bus.raddr0 = 4;
    #1;
    chk("post_rst_wb_cnt",  64'(bus.busy_cnt), 64'd0);
    chk("post_rst_wb_data", bus.rdata0, 64'h4444);
    cycle();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 10000; c++) begin
      rst            = ($urandom_range(0, 199) != 0);
      bus.wen0       = 1'($urandom_range(0, 1));
      bus.wen1       = 1'($urandom_range(0, 1));
      bus.waddr0     = pick_addr();
      bus.waddr1     = pick_addr();
      bus.wdata0     = {$urandom, $urandom};
      bus.wdata1     = {$urandom, $urandom};
      bus.alloc_en   = ($urandom_range(0, 2) != 0);
      bus.alloc_addr = pick_addr();
      case ($urandom_range(0, 3))
        0:       bus.raddr0 = bus.waddr0;
        1:       bus.raddr0 = bus.waddr1;
        default: bus.raddr0 = pick_addr();
      endcase
      case ($urandom_range(0, 3))
        0:       bus.raddr1 = bus.waddr1;
        1:       bus.raddr1 = bus.raddr0;
        default: bus.raddr1 = pick_addr();
      endcase
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, 64, data width in bits.
REQ-002 SHALL have parameter NREG, 32, number of architectural registers (power of two, 2..64).
REQ-003 SHALL have parameter ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy.
REQ-004 SHALL have parameter BYPASS, 1, when 1 same-cycle write data forwards to read ports.
REQ-005 SHALL define AW = clog2(NREG).
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 raddr0/raddr1  input  AW  read addresses, ports 0/1.
REQ-009 rdata0/rdata1  output  XLEN  combinational read data, ports 0/1.
REQ-010 rbusy0/rbusy1  output  1  scoreboard busy bit of raddr0/raddr1.
REQ-011 wen0/wen1  input  1  write enables, ports 0/1.
REQ-012 waddr0/waddr1  input  AW  write addresses.
REQ-013 wdata0/wdata1  input  XLEN  write data.
REQ-014 alloc_en  input  1  mark alloc_addr busy (pending writeback).
REQ-015 alloc_addr  input  AW  register to mark busy.
REQ-016 busy_cnt  output  clog2(NREG)+1  number of busy registers, registered.

Function
REQ-017 SHALL store NREG x XLEN bits; a write with wenN=1 updates regs[waddrN] at the next rising edge.
REQ-018 SHALL ignore writes to address 0 when ZERO_REG=1; rdataN for address 0 SHALL read 0.
REQ-019 On wen0 and wen1 to the same address in one cycle, port 1 data SHALL be stored (port 1 priority).
REQ-020 With BYPASS=1, rdataN SHALL return the same-cycle write data when wenK=1 and waddrK==raddrN (port 1 over port 0, zero-register excepted); with BYPASS=0 rdataN SHALL return stored value only.
REQ-021 Each write (wenN=1, non-zero-register) SHALL clear busy[waddrN] at the next edge.
REQ-022 alloc_en=1 SHALL set busy[alloc_addr] at the next edge; set SHALL win over a same-cycle clear of the same register.
REQ-023 alloc_en to address 0 with ZERO_REG=1 SHALL be ignored.
REQ-024 rbusyN SHALL reflect the current busy register bit (no bypass of same-cycle set/clear).
REQ-025 busy_cnt SHALL equal the population count of the busy vector after each edge, range 0..NREG (NREG-ZERO_REG max).
REQ-026 Re-allocating an already-busy register SHALL leave it busy and busy_cnt unchanged.
REQ-027 Read-port behaviour SHALL be independent: both ports MAY read the same address in one cycle.

Reset
REQ-028 While rst=0 at a rising edge, all registers SHALL become 0, all busy bits 0, busy_cnt 0; writes and allocs that cycle SHALL be discarded.
REQ-029 During the rst=0 cycle rdataN SHALL still present stored contents combinationally (bypass disabled), and rbusyN SHALL present current busy bits.
REQ-030 Reset asserted mid-operation SHALL clear pending busy bits; a writeback arriving after reset SHALL simply write data with busy already 0.

Verification
REQ-031 Reset, then read all addresses -> rdata=0, rbusy=0, busy_cnt=0.
REQ-032 wen0=1 waddr0=5 wdata0=0xDEAD_BEEF, raddr0=5 same cycle -> rdata0=0xDEAD_BEEF same cycle (BYPASS=1), stored value 0xDEAD_BEEF next cycle; with BYPASS=0 -> 0 same cycle.
REQ-033 wen0=wen1=1 waddr0=waddr1=7 wdata0=0x11 wdata1=0x22 -> regs[7]=0x22; wen1 waddr1=0 wdata1=0xFF -> raddr 0 reads 0.
REQ-034 alloc_en addr 3, then addr 9 -> busy_cnt 1 then 2; wen0 waddr0=3 together with alloc_en addr 3 -> rbusy for 3 stays 1, busy_cnt 2.
REQ-035 Allocate 4 registers, assert rst=0 for one cycle -> busy_cnt 0, all rbusy 0, all data 0; following write to 4 -> busy_cnt remains 0.
REQ-036 Random writes/allocs over 10k cycles vs. reference model -> rdata, rbusy, busy_cnt match every cycle.
